// File: rtl/c3aibadapt_cmn_clkgate_pkg.sv
// rtl/c3aibadapt_cmn_clkgate_pkg.sv - clock-gate controller state encoding and helpers
package c3aibadapt_cmn_clkgate_pkg;

  typedef enum logic [1:0] {
    CG_OFF  = 2'd0,
    CG_WAKE = 2'd1,
    CG_ON   = 2'd2,
    CG_HOLD = 2'd3
  } cg_state_e;

  // Smallest counter width able to hold the larger of the two delays.
  function automatic int cg_cnt_w(input int wake_dly, input int idle_dly);
    int m;
    int w;
    m = (wake_dly > idle_dly) ? wake_dly : idle_dly;
    w = 1;
    while ((1 << w) <= m) w++;
    return w;
  endfunction

endpackage

// File: rtl/c3aibadapt_cmn_clkgate_chan.sv
// rtl/c3aibadapt_cmn_clkgate_chan.sv - one gated clock channel: FSM, countdown, enable register, latch gate
module c3aibadapt_cmn_clkgate_chan
  import c3aibadapt_cmn_clkgate_pkg::*;
#(
  parameter int WAKE_DLY = 2,
  parameter int IDLE_DLY = 8,
  parameter int CNT_W    = 8
) (
  input  logic       cp,
  input  logic       srst,
  input  logic       te,
  input  logic       req,
  input  logic       busy,
  output logic       ack,
  output logic       en,
  output logic       clk,
  output logic [1:0] state
);

  localparam int CW_MIN  = cg_cnt_w(WAKE_DLY, IDLE_DLY);
  localparam int CW      = (CNT_W > CW_MIN) ? CNT_W : CW_MIN;
  localparam int WAKE_LD = (WAKE_DLY > 0) ? WAKE_DLY - 1 : 0;
  localparam int IDLE_LD = (IDLE_DLY > 0) ? IDLE_DLY - 1 : 0;

  cg_state_e      st_q, st_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           en_q;
  logic           en_lat;

  always_ff @(posedge cp) begin
    if (srst) begin
      st_q  <= CG_OFF;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      en_q  <= (st_d != CG_OFF);
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      CG_OFF: begin
        if (req) begin
          if (WAKE_DLY == 0) begin
            st_d = CG_ON;
          end else begin
            st_d  = CG_WAKE;
            cnt_d = CW'(WAKE_LD);
          end
        end
      end
      CG_WAKE: begin
        if (!req)                st_d  = CG_OFF;
        else if (cnt_q == '0)    st_d  = CG_ON;
        else                     cnt_d = cnt_q - CW'(1);
      end
      CG_ON: begin
        if (!req && !busy) begin
          if (IDLE_DLY == 0) begin
            st_d = CG_OFF;
          end else begin
            st_d  = CG_HOLD;
            cnt_d = CW'(IDLE_LD);
          end
        end
      end
      CG_HOLD: begin
        // Activity returns to ON; the idle count restarts on the next entry.
        if (req || busy)         st_d  = CG_ON;
        else if (cnt_q == '0)    st_d  = CG_OFF;
        else                     cnt_d = cnt_q - CW'(1);
      end
      default: st_d = CG_OFF;
    endcase
  end

  always_comb begin
    ack   = (st_q == CG_ON) || (st_q == CG_HOLD);
    en    = en_q;
    state = st_q;
  end

  // Latch is transparent only while cp is low, so the enable cannot change during a high phase.
  always_latch begin
    if (!cp) en_lat <= en_q | te;
  end

  assign clk = cp & en_lat;

endmodule

// File: rtl/c3aibadapt_cmn_clkgate_ctrl.sv
// rtl/c3aibadapt_cmn_clkgate_ctrl.sv - multi-channel clock-gate controller top
module c3aibadapt_cmn_clkgate_ctrl
  import c3aibadapt_cmn_clkgate_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WAKE_DLY = 2,
  parameter int IDLE_DLY = 8,
  parameter int CNT_W    = 8
) (
  input  logic                cp,
  input  logic                srst,
  input  logic                te,
  input  logic [NUM_CH-1:0]   ch_req,
  input  logic [NUM_CH-1:0]   ch_busy,
  output logic [NUM_CH-1:0]   ch_ack,
  output logic [NUM_CH-1:0]   ch_clk,
  output logic [NUM_CH-1:0]   ch_en,
  output logic [2*NUM_CH-1:0] ch_state
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    c3aibadapt_cmn_clkgate_chan #(
      .WAKE_DLY (WAKE_DLY),
      .IDLE_DLY (IDLE_DLY),
      .CNT_W    (CNT_W)
    ) u_chan (
      .cp    (cp),
      .srst  (srst),
      .te    (te),
      .req   (ch_req[i]),
      .busy  (ch_busy[i]),
      .ack   (ch_ack[i]),
      .en    (ch_en[i]),
      .clk   (ch_clk[i]),
      .state (ch_state[2*i+1:2*i])
    );
  end

endmodule

// File: tb/tb_c3aibadapt_cmn_clkgate_ctrl.sv
// tb/tb_c3aibadapt_cmn_clkgate_ctrl.sv - self-checking bench for the clock-gate controller
module tb_c3aibadapt_cmn_clkgate_ctrl;

  localparam time HALF = 5;

  logic       cp = 1'b0;
  logic       srst = 1'b1;
  logic       te = 1'b0;
  logic [3:0] a_req = '0, a_busy = '0, a_ack, a_clk, a_en;
  logic [7:0] a_state;
  logic [1:0] b_req = '0, b_busy = '0, b_ack, b_clk, b_en;
  logic [3:0] b_state;

  always #HALF cp = ~cp;

  c3aibadapt_cmn_clkgate_ctrl #(
    .NUM_CH(4), .WAKE_DLY(2), .IDLE_DLY(8), .CNT_W(8)
  ) dut_a (
    .cp(cp), .srst(srst), .te(te), .ch_req(a_req), .ch_busy(a_busy),
    .ch_ack(a_ack), .ch_clk(a_clk), .ch_en(a_en), .ch_state(a_state)
  );

  c3aibadapt_cmn_clkgate_ctrl #(
    .NUM_CH(2), .WAKE_DLY(0), .IDLE_DLY(0), .CNT_W(8)
  ) dut_b (
    .cp(cp), .srst(srst), .te(te), .ch_req(b_req), .ch_busy(b_busy),
    .ch_ack(b_ack), .ch_clk(b_clk), .ch_en(b_en), .ch_state(b_state)
  );

  typedef struct {
    logic       srst;
    logic       te;
    logic [3:0] req;
    logic [3:0] busy;
    logic [7:0] st;
    logic [3:0] ack;
    logic [3:0] en;
  } vec_t;

  typedef struct {
    logic [7:0] st;
    logic [3:0] ack;
    logic [3:0] en;
    logic [3:0] clk;
    logic       chk_clk;
  } exp_t;

  vec_t       vecs[21];
  exp_t       sb[$];
  logic [1:0] bq[$];
  int         n_chk = 0;
  int         n_pass = 0;
  logic [3:0] last_en = '0;
  logic       first = 1'b1;
  logic [3:0] clk_smp;
  logic       mon_on = 1'b0;
  time        t_rise0 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Channel 0 high pulses must always be a full half period wide.
  always @(posedge a_clk[0]) t_rise0 = $time;
  always @(negedge a_clk[0]) begin
    if (mon_on) begin
      n_chk++;
      if ($time - t_rise0 == HALF) n_pass++;
      else $display("FAIL glitch_ch0 width actual=%0t required=%0t", $time - t_rise0, HALF);
    end
  end

  // Called at a negedge: drives one cycle, expects outputs after the next posedge.
  task automatic drive(input logic rst, input logic t, input logic [3:0] rq, input logic [3:0] bz,
                       input logic [7:0] es, input logic [3:0] ea, input logic [3:0] ee);
    exp_t e;
    srst   = rst;
    te     = t;
    a_req  = rq;
    a_busy = bz;
    e.st      = es;
    e.ack     = ea;
    e.en      = ee;
    e.clk     = last_en | {4{t}};
    e.chk_clk = !first;
    sb.push_back(e);
    last_en = ee;
    first   = 1'b0;
    @(posedge cp);
    #1 clk_smp = a_clk;
    @(negedge cp);
    e = sb.pop_front();
    chk("a_state", 32'(a_state), 32'(e.st));
    chk("a_ack",   32'(a_ack),   32'(e.ack));
    chk("a_en",    32'(a_en),    32'(e.en));
    if (e.chk_clk) chk("a_clk_pulse", 32'(clk_smp), 32'(e.clk));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000};
    vecs[3]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000};
    vecs[4]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000};
    vecs[5]  = '{1'b0, 1'b0, 4'b0001, 4'b0000, 8'h01, 4'b0000, 4'b0001};
    vecs[6]  = '{1'b0, 1'b0, 4'b0001, 4'b0000, 8'h01, 4'b0000, 4'b0001};
    vecs[7]  = '{1'b0, 1'b0, 4'b0001, 4'b0000, 8'h02, 4'b0001, 4'b0001};
    vecs[8]  = '{1'b0, 1'b0, 4'b0011, 4'b0000, 8'h06, 4'b0001, 4'b0011};
    vecs[9]  = '{1'b0, 1'b0, 4'b0001, 4'b0000, 8'h02, 4'b0001, 4'b0001};
    vecs[10] = '{1'b0, 1'b0, 4'b0000, 4'b0101, 8'h02, 4'b0001, 4'b0001};
    for (int i = 11; i <= 18; i++)
      vecs[i] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 8'h03, 4'b0001, 4'b0001};
    vecs[19] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000};
    vecs[20] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000};

    @(negedge cp);
    for (int i = 0; i < 21; i++) begin
      if (i == 3) mon_on = 1'b1;
      drive(vecs[i].srst, vecs[i].te, vecs[i].req, vecs[i].busy,
            vecs[i].st, vecs[i].ack, vecs[i].en);
    end

    // HOLD re-entry: busy pulse mid-HOLD restarts the idle countdown.
    drive(0, 0, 4'b0001, 4'b0000, 8'h01, 4'b0000, 4'b0001);
    drive(0, 0, 4'b0001, 4'b0000, 8'h01, 4'b0000, 4'b0001);
    drive(0, 0, 4'b0001, 4'b0000, 8'h02, 4'b0001, 4'b0001);
    for (int i = 0; i < 4; i++)
      drive(0, 0, 4'b0000, 4'b0000, 8'h03, 4'b0001, 4'b0001);
    drive(0, 0, 4'b0000, 4'b0001, 8'h02, 4'b0001, 4'b0001);
    for (int i = 0; i < 8; i++)
      drive(0, 0, 4'b0000, 4'b0000, 8'h03, 4'b0001, 4'b0001);
    drive(0, 0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000);
    drive(0, 0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000);

    // Reset mid-WAKE and mid-HOLD, with channel 3 waking alongside.
    drive(0, 0, 4'b1001, 4'b0000, 8'h41, 4'b0000, 4'b1001);
    drive(1, 0, 4'b1001, 4'b0000, 8'h00, 4'b0000, 4'b0000);
    drive(0, 0, 4'b0001, 4'b0000, 8'h01, 4'b0000, 4'b0001);
    drive(0, 0, 4'b0001, 4'b0000, 8'h01, 4'b0000, 4'b0001);
    drive(0, 0, 4'b0001, 4'b0000, 8'h02, 4'b0001, 4'b0001);
    drive(0, 0, 4'b0000, 4'b0000, 8'h03, 4'b0001, 4'b0001);
    drive(0, 0, 4'b0000, 4'b0000, 8'h03, 4'b0001, 4'b0001);
    drive(1, 0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000);
    drive(0, 0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000);

    // Zero-delay instance: ack and state track req with one cycle of latency.
    begin
      logic [1:0] bpat [8];
      logic [1:0] e;
      bpat = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00};
      for (int i = 0; i < 8; i++) begin
        b_req = bpat[i];
        bq.push_back(bpat[i]);
        @(posedge cp);
        @(negedge cp);
        e = bq.pop_front();
        chk("b_ack", 32'(b_ack), 32'(e));
        chk("b_en",  32'(b_en),  32'(e));
        chk("b_state", 32'(b_state), 32'({e[1] ? 2'd2 : 2'd0, e[0] ? 2'd2 : 2'd0}));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/c3aibadapt_cmn_clkgate_ctrl.md
Name: c3aibadapt_cmn_clkgate_ctrl

Overview:
Multi-channel clock-gate controller for the adapter common block. It provides NUM_CH independently gated copies of one clock, each with a four-phase request/acknowledge wake handshake, a programmable wake settling delay and an idle-hysteresis countdown before the clock is shut off. It sits between the adapter datapath sub-blocks (requesters) and their clock pins, and replaces ad-hoc single gates with per-channel control and glitch-free gating.

Parameters:
NUM_CH, 4, number of independently gated channels (1..32)
WAKE_DLY, 2, cycles from gate-enable to ack assertion (0..255)
IDLE_DLY, 8, idle cycles after req/busy drop before the gate closes (0..255)
CNT_W, 8, countdown width; must hold max(WAKE_DLY, IDLE_DLY)

Ports:
cp  input  1  free-running source clock
srst  input  1  synchronous reset, active-high
te  input  1  scan/test enable; forces every gate open, FSMs unaffected
ch_req  input  NUM_CH  per-channel clock request (level, four-phase)
ch_busy  input  NUM_CH  per-channel activity; holds the clock on while high
ch_ack  output  NUM_CH  clock stable and guaranteed running
ch_clk  output  NUM_CH  gated clock per channel
ch_en  output  NUM_CH  registered gate enable (pre-latch), for observability
ch_state  output  2*NUM_CH  per-channel FSM state, channel i at [2i+1:2i]

Behaviour:
- One clock (cp). Reset is synchronous and active-high (srst). All state updates on the cp rising edge.
- srst high at an edge: every FSM goes to OFF, counters 0, ch_ack=0, ch_en=0, ch_state=0. ch_clk is low from the following cp low phase onward unless te=1. Reset mid-WAKE or mid-HOLD aborts immediately to the same values.
- State encoding: OFF=0, WAKE=1, ON=2, HOLD=3.
- Gate: the enable is ch_en|te, captured by a latch transparent while cp is low. ch_clk = cp & latched enable, so there are no glitches or truncated high pulses.
- OFF: ch_en=0, ch_ack=0. With ch_req=1 at edge N:
  - WAKE_DLY=0: go to ON.
  - Otherwise: go to WAKE with cnt=WAKE_DLY-1.
  - ch_en=1 after edge N. The first ch_clk pulse is at edge N+1.
- WAKE: ch_en=1, ch_ack=0.
  - ch_req=0: go to OFF (abort, no ack).
  - Else cnt==0: go to ON.
  - Else decrement cnt.
  - ch_ack rises after edge N+WAKE_DLY.
- ON: ch_en=1, ch_ack=1. When ch_req=0 and ch_busy=0 at edge M:
  - IDLE_DLY=0: go to OFF.
  - Otherwise: go to HOLD with cnt=IDLE_DLY-1.
- HOLD: ch_en=1, ch_ack=1.
  - ch_req|ch_busy: go to ON (counter discarded, reloaded on next entry).
  - Else cnt==0: go to OFF.
  - Else decrement cnt.
  - The gate closes and ch_ack falls after edge M+IDLE_DLY.
- ch_busy alone never wakes a channel from OFF. It only extends ON/HOLD.
- ch_req and ch_busy are synchronous to cp; no synchroniser is inside the block.
- te does not change ch_en, ch_ack or ch_state.
- Channels are fully independent; simultaneous events on different channels do not interact.

Decomposition:
- Package c3aibadapt_cmn_clkgate_pkg: state encoding constants (CG_OFF, CG_WAKE, CG_ON, CG_HOLD) and a counter-width helper function.
- Sub-module c3aibadapt_cmn_clkgate_chan: one FSM, counter, enable register, latch and AND gate.
- The top level instantiates the sub-module NUM_CH times in a generate loop and packs ch_state.

Test Plan:
1. Reset, WAKE_DLY=2: srst held 3 cycles, then req=0 -> ch_clk low, ch_ack=0, ch_state=0 on all channels; te=1 -> ch_clk toggles, ch_state still 0.
2. Wake, WAKE_DLY=2: ch_req[0] 0->1 at edge 10 -> ch_en[0]=1 after edge 10, first ch_clk[0] pulse at edge 11, ch_ack[0]=1 after edge 12; other channels stay OFF.
3. Idle, IDLE_DLY=8, channel 0 ON: req and busy drop at edge 20 -> ch_state=HOLD; ch_ack=0, ch_en=0, state OFF after edge 28; no ch_clk pulse after edge 28.
4. HOLD re-entry: in HOLD at edge 24, ch_busy=1 for 1 cycle -> return to ON; OFF occurs 8 cycles after busy falls, not at edge 28.
5. Abort and zero delays: ch_req pulse of 1 cycle with WAKE_DLY=2 -> WAKE then OFF, ch_ack never rises. With WAKE_DLY=0 and IDLE_DLY=0, ch_ack follows ch_req with exactly 1 cycle latency.
6. Reset mid-operation: srst at edge 5 of WAKE and during HOLD -> OFF next edge, ch_ack=0; ch_clk high pulses remain full width, checked by a glitch monitor.
